// File: rtl/xoodoo_sca_pkg.sv
// xoodoo_sca_pkg
// Shared definitions for the masked Xoodoo randomness source: lane geometry,
// the zero-lane replacement constant, the rdi generator FSM encoding and the
// helper that merges one seed word into a state lane.
package xoodoo_sca_pkg;

    localparam int NLANES = 12;
    localparam int LANE_W = 32;
    localparam int RDI_W  = NLANES * LANE_W;

    // xorshift32 has a fixed point at zero, so a lane may never be left at 0.
    localparam logic [LANE_W-1:0] RDI_ZERO_FIX = 32'h9E3779B9;

    localparam logic [3:0] LAST_LANE = 4'd11;

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        READY = 2'd1,
        OUT0  = 2'd2,
        OUT1  = 2'd3
    } rdi_state_e;

    // Merge a seed word into a lane (overwrite or XOR-in) and replace a zero
    // result by the lane-specific fix constant.
    function automatic logic [LANE_W-1:0] seed_lane(
        input logic [LANE_W-1:0] old_lane,
        input logic [LANE_W-1:0] word,
        input logic              xor_in,
        input logic [3:0]        lane_idx
    );
        logic [LANE_W-1:0] merged;
        merged = xor_in ? (old_lane ^ word) : word;
        if (merged == '0) begin
            merged = RDI_ZERO_FIX ^ {28'd0, lane_idx};
        end
        return merged;
    endfunction

endpackage

// File: rtl/xoodoo_rdi_gen_if.sv
// xoodoo_rdi_gen_if
// Bundles the seed input channel and the randomness request/output channel.
//   seed_data/seed_valid -> seed_ready : word-serial seeding handshake
//   req -> ready                       : one word pair per accepted request
//   rdi, rdi0_en, rdi1_en              : 384-bit random word and share strobes
// master: the side that seeds and requests; slave: the generator.
interface xoodoo_rdi_gen_if;
    import xoodoo_sca_pkg::*;

    logic [LANE_W-1:0] seed_data;
    logic              seed_valid;
    logic              seed_ready;
    logic              req;
    logic              ready;
    logic [RDI_W-1:0]  rdi;
    logic              rdi0_en;
    logic              rdi1_en;

    modport master (
        output seed_data, seed_valid, req,
        input  seed_ready, ready, rdi, rdi0_en, rdi1_en
    );

    modport slave (
        input  seed_data, seed_valid, req,
        output seed_ready, ready, rdi, rdi0_en, rdi1_en
    );

endinterface

// File: rtl/xoodoo_xs32_step.sv
// xoodoo_xs32_step
// Purely combinational xorshift32 step for one 32-bit lane:
//   x ^= x << 13; x ^= x >> 17; x ^= x << 5
// Ports: x_i current lane value, x_o next lane value.
module xoodoo_xs32_step
    import xoodoo_sca_pkg::*;
(
    input  logic [LANE_W-1:0] x_i,
    output logic [LANE_W-1:0] x_o
);

    logic [LANE_W-1:0] t1;
    logic [LANE_W-1:0] t2;

    // Three shift/XOR stages of the generator.
    always_comb begin
        t1  = x_i ^ (x_i << 13);
        t2  = t1 ^ (t1 >> 17);
        x_o = t2 ^ (t2 << 5);
    end

endmodule

// File: rtl/xoodoo_rdi_gen.sv
// xoodoo_rdi_gen
// Fresh-randomness source for the first-order threshold Xoodoo round. Holds a
// 12 x 32-bit xorshift32 state, seeded word-serially, and emits two 384-bit
// words per request: word A with rdi0_en, then word B with rdi1_en.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : xoodoo_rdi_gen_if.slave (seed channel, req/ready, rdi + strobes)
// Parameter RESEED_PERIOD (1..65535): word pairs between forced reseeds.
// Optional feature macro XOODOO_RDI_RESEED_EN: adds a pair counter that sends
// the FSM back to SEED every RESEED_PERIOD pairs; reseed words are XORed into
// the existing state.
module xoodoo_rdi_gen
    import xoodoo_sca_pkg::*;
#(
    parameter int RESEED_PERIOD = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    xoodoo_rdi_gen_if.slave       bus
);

    if (RESEED_PERIOD < 1 || RESEED_PERIOD > 65535) begin : g_bad_period
        $error("xoodoo_rdi_gen: RESEED_PERIOD must be in 1..65535");
    end

    rdi_state_e state_q, state_d;
    logic [3:0] lane_cnt_q, lane_cnt_d;
    logic [NLANES-1:0][LANE_W-1:0] lanes_q, lanes_d;
    logic [NLANES-1:0][LANE_W-1:0] lanes_step;
    logic [RDI_W-1:0] rdi_q, rdi_d;
    logic xor_in;
    logic req_ok;
    logic emit;

`ifdef XOODOO_RDI_RESEED_EN
    logic [15:0] pair_cnt_q, pair_cnt_d;
    // The very first seed starts from an all-zero state, so XOR-in is
    // identical to overwriting there.
    assign xor_in = 1'b1;
`else
    assign xor_in = 1'b0;
`endif

    for (genvar k = 0; k < NLANES; k++) begin : g_step
        xoodoo_xs32_step u_step (
            .x_i (lanes_q[k]),
            .x_o (lanes_step[k])
        );
    end

    assign bus.rdi = rdi_q;

    // Next-state logic. The state register advances only on the edge that
    // enters OUT0 or OUT1, and the same stepped value is loaded into rdi so
    // the word is visible in the cycle its strobe is high.
    always_comb begin
        state_d        = state_q;
        lane_cnt_d     = lane_cnt_q;
        lanes_d        = lanes_q;
        rdi_d          = rdi_q;
        emit           = 1'b0;
        req_ok         = 1'b0;
        bus.seed_ready = 1'b0;
        bus.ready      = 1'b0;
        bus.rdi0_en    = 1'b0;
        bus.rdi1_en    = 1'b0;
`ifdef XOODOO_RDI_RESEED_EN
        pair_cnt_d     = pair_cnt_q;
`endif

        case (state_q)
            SEED: begin
                bus.seed_ready = 1'b1;
                if (bus.seed_valid) begin
                    for (int k = 0; k < NLANES; k++) begin
                        if (lane_cnt_q == 4'(k)) begin
                            lanes_d[k] = seed_lane(lanes_q[k], bus.seed_data, xor_in, 4'(k));
                        end
                    end
                    if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d = 4'd0;
                        state_d    = READY;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 4'd1;
                    end
                end
            end
            READY: begin
                req_ok = 1'b1;
            end
            OUT0: begin
                bus.rdi0_en = 1'b1;
                emit        = 1'b1;
                state_d     = OUT1;
            end
            OUT1: begin
                bus.rdi1_en = 1'b1;
                req_ok      = 1'b1;
                state_d     = READY;
`ifdef XOODOO_RDI_RESEED_EN
                // A due reseed takes priority: the request is not sampled.
                pair_cnt_d = pair_cnt_q + 16'd1;
                if (pair_cnt_d == 16'(RESEED_PERIOD)) begin
                    pair_cnt_d = 16'd0;
                    req_ok     = 1'b0;
                    state_d    = SEED;
                end
`endif
            end
            default: begin
                state_d = SEED;
            end
        endcase

        bus.ready = req_ok;
        if (req_ok && bus.req) begin
            state_d = OUT0;
            emit    = 1'b1;
        end

        if (emit) begin
            lanes_d = lanes_step;
            rdi_d   = lanes_step;
        end
    end

    // State, counters and output register; reset forces a full reseed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= SEED;
            lane_cnt_q <= 4'd0;
            lanes_q    <= '0;
            rdi_q      <= '0;
`ifdef XOODOO_RDI_RESEED_EN
            pair_cnt_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            lanes_q    <= lanes_d;
            rdi_q      <= rdi_d;
`ifdef XOODOO_RDI_RESEED_EN
            pair_cnt_q <= pair_cnt_d;
`endif
        end
    end

endmodule
